// File: rtl/pattern_check_pkg.sv
// Pattern checker shared definitions.
// Holds the sequencer state type, width helper functions and the default
// parameter values used by the interface and the checker modules.
// No ports.
package pattern_check_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int DEF_IN_W    = 60;
    localparam int DEF_OUT_W   = 26;
    localparam int DEF_NUM_PAT = 5;
    localparam int DEF_SETTLE  = 1;

    // Bits needed to address n patterns (n >= 2).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to count 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to hold the settle countdown start value s-1.
    function automatic int settle_width(input int s);
        return (s <= 2) ? 1 : $clog2(s);
    endfunction

endpackage

// File: rtl/pattern_check_seq_if.sv
// Pattern checker data bus: ROM read side and DUT drive/observe side.
// master : pattern_check_seq (drives pat_idx and dut_in)
// slave  : ROM + DUT environment (drives stim/gold/mask and dut_out)
//   pat_idx   ROM address, asynchronous read
//   stim_data stimulus word at pat_idx
//   gold_data expected DUT response at pat_idx
//   gold_mask 1 = bit checked, 0 = don't-care
//   dut_in    registered stimulus to the DUT
//   dut_out   DUT response
interface pattern_check_seq_if
    import pattern_check_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int IDX_W = idx_width(DEF_NUM_PAT)
);

    logic [IDX_W-1:0] pat_idx;
    logic [IN_W-1:0]  stim_data;
    logic [OUT_W-1:0] gold_data;
    logic [OUT_W-1:0] gold_mask;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;

    modport master (
        output pat_idx,
        output dut_in,
        input  stim_data,
        input  gold_data,
        input  gold_mask,
        input  dut_out
    );

    modport slave (
        input  pat_idx,
        input  dut_in,
        output stim_data,
        output gold_data,
        output gold_mask,
        output dut_out
    );

endinterface

// File: rtl/pattern_cmp.sv
// Masked response comparator, purely combinational.
//   dut_out  observed DUT response
//   gold     expected response
//   mask     1 = bit checked, 0 = don't-care
//   diff     per-bit masked difference
//   mismatch any checked bit differs
module pattern_cmp #(
    parameter int OUT_W = 26
) (
    input  logic [OUT_W-1:0] dut_out,
    input  logic [OUT_W-1:0] gold,
    input  logic [OUT_W-1:0] mask,
    output logic [OUT_W-1:0] diff,
    output logic             mismatch
);

    assign diff     = (dut_out ^ gold) & mask;
    assign mismatch = |diff;

endmodule

// File: rtl/pattern_check_seq.sv
// Pattern sequencer/checker for a combinational DUT.
// Walks NUM_PAT ROM entries, drives each stimulus to the DUT, waits SETTLE
// cycles, compares under the don't-care mask and keeps pass/fail counts plus
// the index and difference of the first failing pattern.
//   clk, rst        clock, synchronous active-high reset
//   start           begin a run (honoured only in IDLE or DONE)
//   bus             ROM and DUT bus (master side)
//   busy            high in APPLY/WAIT/CHECK
//   done            high in DONE until the next start or reset
//   pass_cnt        passing patterns this run
//   fail_cnt        failing patterns this run
//   all_pass        done with no failures
//   first_fail_*    valid flag, index and masked diff of first failure
//
// state | meaning
// IDLE  | waiting for start after reset
// APPLY | register stimulus, golden and mask for pat_idx
// WAIT  | let the DUT settle for SETTLE cycles
// CHECK | compare and update counters, advance or finish
// DONE  | run finished, results held
module pattern_check_seq
    import pattern_check_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int NUM_PAT = DEF_NUM_PAT,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int IDX_W   = idx_width(NUM_PAT),
    parameter int CNT_W   = cnt_width(NUM_PAT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    pattern_check_seq_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 all_pass,
    output logic                 first_fail_vld,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic [OUT_W-1:0]     first_fail_diff
);

    localparam int SET_W = settle_width(SETTLE);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] pat_idx_q, pat_idx_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic [OUT_W-1:0] gold_q, gold_d;
    logic [OUT_W-1:0] mask_q, mask_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             ffv_q, ffv_d;
    logic [IDX_W-1:0] ffi_q, ffi_d;
    logic [OUT_W-1:0] ffd_q, ffd_d;

    logic [OUT_W-1:0] diff;
    logic             mismatch;

    pattern_cmp #(
        .OUT_W (OUT_W)
    ) u_cmp (
        .dut_out  (bus.dut_out),
        .gold     (gold_q),
        .mask     (mask_q),
        .diff     (diff),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_idx_q <= '0;
            dut_in_q  <= '0;
            gold_q    <= '0;
            mask_q    <= '0;
            settle_q  <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            ffv_q     <= 1'b0;
            ffi_q     <= '0;
            ffd_q     <= '0;
        end else begin
            state_q   <= state_d;
            pat_idx_q <= pat_idx_d;
            dut_in_q  <= dut_in_d;
            gold_q    <= gold_d;
            mask_q    <= mask_d;
            settle_q  <= settle_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ffv_q     <= ffv_d;
            ffi_q     <= ffi_d;
            ffd_q     <= ffd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_idx_d = pat_idx_q;
        dut_in_d  = dut_in_q;
        gold_d    = gold_q;
        mask_d    = mask_q;
        settle_d  = settle_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ffv_d     = ffv_q;
        ffi_d     = ffi_q;
        ffd_d     = ffd_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pat_idx_d = '0;
                    pass_d    = '0;
                    fail_d    = '0;
                    ffv_d     = 1'b0;
                    ffi_d     = '0;
                    ffd_d     = '0;
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                dut_in_d = bus.stim_data;
                gold_d   = bus.gold_data;
                mask_d   = bus.gold_mask;
                settle_d = SET_W'(SETTLE - 1);
                state_d  = WAIT;
            end
            WAIT: begin
                // Counter loaded with SETTLE-1, so WAIT spans exactly SETTLE cycles.
                if (settle_q == '0) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_d = fail_q + CNT_W'(1);
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = pat_idx_q;
                        ffd_d = diff;
                    end
                end else begin
                    pass_d = pass_q + CNT_W'(1);
                end
                if (pat_idx_q == IDX_W'(NUM_PAT - 1)) begin
                    state_d = DONE;
                end else begin
                    pat_idx_d = pat_idx_q + IDX_W'(1);
                    state_d   = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pat_idx     = pat_idx_q;
    assign bus.dut_in      = dut_in_q;
    assign busy            = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
    assign done            = (state_q == DONE);
    assign pass_cnt        = pass_q;
    assign fail_cnt        = fail_q;
    assign all_pass        = done && (fail_q == '0);
    assign first_fail_vld  = ffv_q;
    assign first_fail_idx  = ffi_q;
    assign first_fail_diff = ffd_q;

endmodule

// File: tb/tb_pattern_check_seq.sv
// Self-checking bench for pattern_check_seq.
// Three checker instances (8-bit, 5 patterns): unit 0 SETTLE=1 with a
// loopback DUT, unit 1 SETTLE=3 and unit 2 SETTLE=2, both against a DUT that
// returns its input three cycles late.
module tb_pattern_check_seq;

    localparam int W  = 8;
    localparam int NP = 5;
    localparam int IW = 3;
    localparam int CW = 3;
    localparam int  SET_TBL [3] = '{1, 3, 2};
    localparam bit  DLY_TBL [3] = '{1'b0, 1'b1, 1'b1};
    localparam logic [W-1:0] BASE [NP] = '{8'h3C, 8'hA5, 8'h5A, 8'h81, 8'h7E};

    typedef struct {
        int           pass_n;
        int           fail_n;
        int           vld;
        int           idx;
        logic [W-1:0] diff;
        int           edge_n;
    } res_t;

    typedef struct {
        int   u;
        int   variant;
        res_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start     [3];
    logic [W-1:0]  stim_rom  [3][8];
    logic [W-1:0]  gold_rom  [3][8];
    logic [W-1:0]  mask_rom  [3][8];
    logic          busy      [3];
    logic          done      [3];
    logic [CW-1:0] pass_cnt  [3];
    logic [CW-1:0] fail_cnt  [3];
    logic          all_pass  [3];
    logic          ffv       [3];
    logic [IW-1:0] ffi       [3];
    logic [W-1:0]  ffd       [3];
    logic [W-1:0]  dut_in_s  [3];
    logic [IW-1:0] pat_idx_s [3];
    logic [W-1:0]  prev_in   [3];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : g_u
        pattern_check_seq_if #(.IN_W(W), .OUT_W(W), .IDX_W(IW)) bus ();
        logic [W-1:0] d1 = '0;
        logic [W-1:0] d2 = '0;
        logic [W-1:0] d3 = '0;

        always_ff @(posedge clk) begin
            d1 <= bus.dut_in;
            d2 <= d1;
            d3 <= d2;
        end

        assign bus.stim_data = stim_rom[g][bus.pat_idx];
        assign bus.gold_data = gold_rom[g][bus.pat_idx];
        assign bus.gold_mask = mask_rom[g][bus.pat_idx];
        assign bus.dut_out   = DLY_TBL[g] ? d3 : bus.dut_in;
        assign dut_in_s[g]   = bus.dut_in;
        assign pat_idx_s[g]  = bus.pat_idx;

        pattern_check_seq #(
            .IN_W    (W),
            .OUT_W   (W),
            .NUM_PAT (NP),
            .SETTLE  (SET_TBL[g])
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .start           (start[g]),
            .bus             (bus),
            .busy            (busy[g]),
            .done            (done[g]),
            .pass_cnt        (pass_cnt[g]),
            .fail_cnt        (fail_cnt[g]),
            .all_pass        (all_pass[g]),
            .first_fail_vld  (ffv[g]),
            .first_fail_idx  (ffi[g]),
            .first_fail_diff (ffd[g])
        );
    end

    task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s unit%0d: got %0h expected %0h", name, u, act, exp);
        end
    endtask

    // variant 0: gold=stim, full mask; 1: gold[2] bit3 flipped;
    // 2: as 1 with mask[2]=F7; 3: as 1 plus gold[4] bit6 flipped
    task automatic fill(input int u, input int variant);
        for (int i = 0; i < 8; i++) begin
            stim_rom[u][i] = (i < NP) ? BASE[i] : '0;
            gold_rom[u][i] = (i < NP) ? BASE[i] : '0;
            mask_rom[u][i] = (i < NP) ? 8'hFF : '0;
        end
        if (variant >= 1) gold_rom[u][2] = gold_rom[u][2] ^ 8'h08;
        if (variant == 2) mask_rom[u][2] = 8'hF7;
        if (variant == 3) gold_rom[u][4] = gold_rom[u][4] ^ 8'h40;
    endtask

    // Observed response: a DUT lagging 3 cycles is only seen correctly when
    // the settle time covers the lag; with SETTLE=2 the comparator sees the
    // previous stimulus instead.
    function automatic res_t model(input int u);
        res_t r;
        logic [W-1:0] obs, d;
        r.pass_n = 0; r.fail_n = 0; r.vld = 0; r.idx = 0; r.diff = '0;
        r.edge_n = NP * (SET_TBL[u] + 2);
        for (int i = 0; i < NP; i++) begin
            if (DLY_TBL[u] && SET_TBL[u] < 3)
                obs = (i == 0) ? prev_in[u] : stim_rom[u][i-1];
            else
                obs = stim_rom[u][i];
            d = (obs ^ gold_rom[u][i]) & mask_rom[u][i];
            if (d != '0) begin
                r.fail_n++;
                if (r.vld == 0) begin
                    r.vld = 1; r.idx = i; r.diff = d;
                end
            end else begin
                r.pass_n++;
            end
        end
        return r;
    endfunction

    task automatic run(input int u, input int busy_pulse, output res_t got);
        @(negedge clk) start[u] = 1'b1;
        @(posedge clk);
        @(negedge clk) start[u] = 1'b0;
        chk("done_clr", u, 32'(done[u]), 32'd0);
        chk("cnt_clr", u, 32'({pass_cnt[u], fail_cnt[u], ffv[u]}), 32'd0);
        got.edge_n = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            start[u] = (k == busy_pulse);
            if (done[u]) begin
                got.edge_n = k;
                break;
            end
        end
        start[u] = 1'b0;
        if (got.edge_n < 0) $display("FAIL timeout unit%0d: got no done expected done", u);
        got.pass_n = int'(pass_cnt[u]);
        got.fail_n = int'(fail_cnt[u]);
        got.vld    = int'(ffv[u]);
        got.idx    = int'(ffi[u]);
        got.diff   = ffd[u];
        chk("busy_at_done", u, 32'(busy[u]), 32'd0);
        chk("dut_in_hold", u, 32'(dut_in_s[u]), 32'(stim_rom[u][NP-1]));
        prev_in[u] = stim_rom[u][NP-1];
    endtask

    task automatic cmp_res(input string tag, input int u, input res_t g, input res_t e);
        chk({tag, ".edge"}, u, g.edge_n, e.edge_n);
        chk({tag, ".pass"}, u, g.pass_n, e.pass_n);
        chk({tag, ".fail"}, u, g.fail_n, e.fail_n);
        chk({tag, ".vld"},  u, g.vld, e.vld);
        chk({tag, ".idx"},  u, g.idx, e.idx);
        chk({tag, ".diff"}, u, 32'(g.diff), 32'(e.diff));
        chk({tag, ".all"},  u, 32'(all_pass[u]), 32'(e.fail_n == 0));
    endtask

    task automatic chk_zero(input string tag, input int u);
        chk({tag, ".busy"}, u, 32'(busy[u]), 0);
        chk({tag, ".done"}, u, 32'(done[u]), 0);
        chk({tag, ".cnt"},  u, 32'({pass_cnt[u], fail_cnt[u]}), 0);
        chk({tag, ".ff"},   u, 32'({ffv[u], ffi[u], ffd[u]}), 0);
        chk({tag, ".all"},  u, 32'(all_pass[u]), 0);
        chk({tag, ".io"},   u, 32'({dut_in_s[u], pat_idx_s[u]}), 0);
    endtask

    vec_t vecs [7];
    res_t got, e;

    initial begin
        vecs[0] = '{0, 0, '{5, 0, 0, 0, 8'h00, 15}};
        vecs[1] = '{0, 1, '{4, 1, 1, 2, 8'h08, 15}};
        vecs[2] = '{0, 2, '{5, 0, 0, 0, 8'h00, 15}};
        vecs[3] = '{0, 3, '{3, 2, 1, 2, 8'h08, 15}};
        vecs[4] = '{1, 0, '{5, 0, 0, 0, 8'h00, 25}};
        vecs[5] = '{2, 0, '{0, 5, 1, 0, 8'h3C, 20}};
        vecs[6] = '{2, 0, '{0, 5, 1, 0, 8'h42, 20}};

        for (int u = 0; u < 3; u++) begin
            start[u] = 1'b0;
            prev_in[u] = '0;
            fill(u, 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int u = 0; u < 3; u++) chk_zero("reset", u);

        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].u, vecs[v].variant);
            run(vecs[v].u, 0, got);
            cmp_res($sformatf("vec%0d", v), vecs[v].u, got, vecs[v].e);
        end

        // start pulsed mid-run is ignored; start while done restarts cleanly
        fill(0, 3);
        run(0, 7, got);
        cmp_res("busy_start", 0, got, vecs[3].e);
        run(0, 0, got);
        cmp_res("restart", 0, got, vecs[3].e);

        // reset during pattern 3's WAIT (APPLY of pattern 3 is edge 10)
        fill(0, 0);
        @(negedge clk) start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk) start[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_rst.pass", 0, 32'(pass_cnt[0]), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 3; u++) chk_zero("mid_rst", u);
        for (int u = 0; u < 3; u++) prev_in[u] = '0;
        repeat (4) @(posedge clk);
        fill(0, 1);
        run(0, 0, got);
        cmp_res("post_rst", 0, got, vecs[1].e);

        // randomized runs against the reference model
        for (int t = 0; t < 16; t++) begin
            int u;
            u = int'($urandom_range(0, 2));
            for (int i = 0; i < 8; i++) begin
                stim_rom[u][i] = '0; gold_rom[u][i] = '0; mask_rom[u][i] = '0;
            end
            for (int i = 0; i < NP; i++) begin
                int sel;
                stim_rom[u][i] = W'($urandom);
                gold_rom[u][i] = stim_rom[u][i];
                if ($urandom_range(0, 2) == 0)
                    gold_rom[u][i] = gold_rom[u][i] ^ W'(1 << $urandom_range(0, 7));
                sel = int'($urandom_range(0, 3));
                mask_rom[u][i] = (sel == 0) ? 8'h00 : (sel == 1) ? W'($urandom) : 8'hFF;
            end
            e = model(u);
            run(u, 0, got);
            cmp_res($sformatf("rand%0d", t), u, got, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
